mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 clk  input  1  rising-edge clock; reset  input  1  asynchronous, active-high reset.
REQ-002 MemtoReg_i  input  2  writeback select from EX/MEM register.
REQ-003 Branch_i, MemRead_i, MemWrite_i, RegWrite_i  input  1 each  control bits from EX/MEM.
REQ-004 PC_beq_i  input  32  branch target; alu_result_i  input  32  address or ALU value.
REQ-005 ReadData2_i  input  32  store data; zero_flag_i  input  1  ALU zero.
REQ-006 WriteRegister_i  input  5  destination register number.
REQ-007 dmem_req  output  1  data-bus request; dmem_we  output  1  write enable.
REQ-008 dmem_addr  output  32  word address; dmem_wdata  output  32  store data.
REQ-009 dmem_ack  input  1  access complete; dmem_rdata  input  32  load data, valid with ack.
REQ-010 stall  output  1  hold upstream stages and EX/MEM contents.
REQ-011 PCSrc  output  1  branch taken; PC_branch  output  32  branch target.
REQ-012 MemtoReg_o  output  2;  RegWrite_o  output  1;  WriteRegister_o  output  5  MEM/WB control.
REQ-013 read_data_o  output  32;  alu_result_o  output  32  MEM/WB data.
REQ-014 bus_err_o  output  1  timeout pulse; misalign_o  output  1  misaligned-access pulse.

Function
REQ-015 FSM states IDLE, ACCESS; mem op = MemRead_i | MemWrite_i.
REQ-016 IDLE, no mem op: stall=0; MEM/WB outputs load inputs at next edge (1-cycle latency).
REQ-017 IDLE, mem op: stall=1 combinationally; next state ACCESS; MEM/WB loads bubble (RegWrite_o=0).
REQ-018 ACCESS: dmem_req=1 (decoded from registered state); dmem_we=MemWrite_i; addr/wdata held stable from inputs.
REQ-019 ACCESS, dmem_ack=1: stall=0 same cycle; read_data_o<=dmem_rdata, other MEM/WB fields from inputs; next state IDLE.
REQ-020 ACCESS, dmem_ack=0: stall=1; MEM/WB loads bubble; 8-bit wait counter increments.
REQ-021 Wait counter reaching 255 without ack: abort, stall=0, bus_err_o=1 for one cycle, RegWrite_o=0, read_data_o=0, state IDLE.
REQ-022 Minimum load/store latency 2 cycles (IDLE cycle + ack in first ACCESS cycle).
REQ-023 dmem_ack in IDLE ignored; wait counter cleared on every entry to ACCESS.
REQ-024 PCSrc = Branch_i & zero_flag_i, combinational; PC_branch = PC_beq_i pass-through.
REQ-025 Stores: RegWrite_o follows RegWrite_i (normally 0); read_data_o unchanged on store completion.

Reset
REQ-026 reset: state IDLE, counter 0, all registered outputs 0, dmem_req=0 immediately, including mid-ACCESS; a late ack after reset is ignored.

Configuration
REQ-027 MEM_ALIGN_CHECK_EN defined: mem op with alu_result_i[1:0]!=0 issues no request, stall=0, misalign_o=1 one cycle, RegWrite_o=0.
REQ-028 MEM_ALIGN_CHECK_EN undefined: dmem_addr[1:0] forced 00; misalign_o tied 0.

Structure
REQ-029 Package mem_stage_pkg: state enum, TIMEOUT_MAX=255, MemtoReg encodings (00 ALU, 01 memory, 10 PC+4).
REQ-030 Sub-module dmem_access_fsm: state register, wait counter, dmem_req/stall/bus_err_o generation; MEM/WB register kept in mem_stage.

Verification
REQ-031 ALU op, alu_result_i=0x1234, RegWrite_i=1, WriteRegister_i=5 -> next edge alu_result_o=0x1234, RegWrite_o=1, stall never 1.
REQ-032 Load addr 0x100, ack after 3 ACCESS cycles, rdata 0xDEADBEEF -> stall high 4 cycles, read_data_o=0xDEADBEEF, exactly one dmem_req burst.
REQ-033 Store addr 0x200, data 0xCAFE, ack first ACCESS cycle -> dmem_we=1, dmem_wdata=0xCAFE, stall 1 cycle, RegWrite_o=0.
REQ-034 Branch_i=1, zero_flag_i=1, PC_beq_i=0x40 -> PCSrc=1, PC_branch=0x40 same cycle; zero_flag_i=0 -> PCSrc=0.
REQ-035 Load, no ack -> bus_err_o pulse once 255 ACCESS cycles elapse, stall releases, RegWrite_o=0.
REQ-036 reset asserted mid-ACCESS, then ack -> dmem_req=0 at once, state IDLE, no MEM/WB update; with MEM_ALIGN_CHECK_EN, load addr 0x102 -> misalign_o pulse, no dmem_req.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared types and constants for the MEM pipeline stage
package mem_stage_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_t;

  localparam logic [7:0] TIMEOUT_MAX = 8'd255;

  localparam logic [1:0] MTR_ALU = 2'b00;
  localparam logic [1:0] MTR_MEM = 2'b01;
  localparam logic [1:0] MTR_PC4 = 2'b10;

  function automatic logic [31:0] word_addr(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// rtl/mem_stage_if.sv - data-memory bus between the MEM stage and the memory
interface mem_stage_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/mem_stage_dmem_access_fsm.sv
// rtl/mem_stage_dmem_access_fsm.sv - data-bus access FSM with wait counter and timeout
module dmem_access_fsm
  import mem_stage_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic mem_op,
  input  logic misaligned,
  input  logic dmem_ack,
  output logic dmem_req,
  output logic stall,
  output logic bus_err_o,
  output logic misalign_o,
  output logic complete,
  output logic timeout,
  output logic wb_bubble
);

  state_t     state;
  logic [7:0] wait_cnt;
  logic       reject;

  // Request decodes straight from the state register so reset drops it at once.
  assign dmem_req = (state == ST_ACCESS);

  always_comb begin
    complete  = 1'b0;
    timeout   = 1'b0;
    reject    = 1'b0;
    stall     = 1'b0;
    wb_bubble = 1'b0;
    if (state == ST_IDLE) begin
      reject = mem_op & misaligned;
      stall  = mem_op & ~misaligned;
    end else begin
      complete = dmem_ack;
      timeout  = ~dmem_ack & (wait_cnt == TIMEOUT_MAX);
      stall    = ~dmem_ack & ~timeout;
    end
    wb_bubble = stall | timeout | reject;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      wait_cnt   <= 8'd0;
      bus_err_o  <= 1'b0;
      misalign_o <= 1'b0;
    end else begin
      bus_err_o  <= timeout;
      misalign_o <= reject;
      case (state)
        ST_IDLE: begin
          if (mem_op && !misaligned) begin
            state    <= ST_ACCESS;
            wait_cnt <= 8'd0;
          end
        end
        ST_ACCESS: begin
          if (dmem_ack || timeout) begin
            state <= ST_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MEM pipeline stage with MEM/WB register; MEM_ALIGN_CHECK_EN enables misalignment rejection
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  MemtoReg_i,
  input  logic        Branch_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic        RegWrite_i,
  input  logic [31:0] PC_beq_i,
  input  logic [31:0] alu_result_i,
  input  logic [31:0] ReadData2_i,
  input  logic        zero_flag_i,
  input  logic [4:0]  WriteRegister_i,
  mem_stage_if.master dmem,
  output logic        stall,
  output logic        PCSrc,
  output logic [31:0] PC_branch,
  output logic [1:0]  MemtoReg_o,
  output logic        RegWrite_o,
  output logic [4:0]  WriteRegister_o,
  output logic [31:0] read_data_o,
  output logic [31:0] alu_result_o,
  output logic        bus_err_o,
  output logic        misalign_o
);

  logic mem_op;
  logic misaligned;
  logic req;
  logic complete;
  logic timeout;
  logic wb_bubble;

  assign mem_op = MemRead_i | MemWrite_i;

`ifdef MEM_ALIGN_CHECK_EN
  assign misaligned     = |alu_result_i[1:0];
  assign dmem.dmem_addr = alu_result_i;
`else
  assign misaligned     = 1'b0;
  assign dmem.dmem_addr = word_addr(alu_result_i);
`endif

  dmem_access_fsm u_fsm (
    .clk        (clk),
    .reset      (reset),
    .mem_op     (mem_op),
    .misaligned (misaligned),
    .dmem_ack   (dmem.dmem_ack),
    .dmem_req   (req),
    .stall      (stall),
    .bus_err_o  (bus_err_o),
    .misalign_o (misalign_o),
    .complete   (complete),
    .timeout    (timeout),
    .wb_bubble  (wb_bubble)
  );

  assign dmem.dmem_req   = req;
  assign dmem.dmem_we    = req & MemWrite_i;
  assign dmem.dmem_wdata = ReadData2_i;

  assign PCSrc     = Branch_i & zero_flag_i;
  assign PC_branch = PC_beq_i;

  // Bubbles only kill RegWrite; the other fields are don't-care while it is low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      MemtoReg_o      <= 2'b00;
      RegWrite_o      <= 1'b0;
      WriteRegister_o <= 5'd0;
      read_data_o     <= 32'd0;
      alu_result_o    <= 32'd0;
    end else begin
      MemtoReg_o      <= MemtoReg_i;
      WriteRegister_o <= WriteRegister_i;
      alu_result_o    <= alu_result_i;
      RegWrite_o      <= wb_bubble ? 1'b0 : RegWrite_i;
      if (timeout) begin
        read_data_o <= 32'd0;
      end else if (complete && MemRead_i) begin
        read_data_o <= dmem.dmem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - directed self-checking bench for mem_stage
module tb_mem_stage;
  logic        clk;
  logic        reset;
  logic [1:0]  MemtoReg_i;
  logic        Branch_i, MemRead_i, MemWrite_i, RegWrite_i;
  logic [31:0] PC_beq_i, alu_result_i, ReadData2_i;
  logic        zero_flag_i;
  logic [4:0]  WriteRegister_i;
  logic        stall, PCSrc;
  logic [31:0] PC_branch;
  logic [1:0]  MemtoReg_o;
  logic        RegWrite_o;
  logic [4:0]  WriteRegister_o;
  logic [31:0] read_data_o, alu_result_o;
  logic        bus_err_o, misalign_o;

  int vectors;
  int miscompares;

  mem_stage_if dmem();

  mem_stage dut (
    .clk             (clk),
    .reset           (reset),
    .MemtoReg_i      (MemtoReg_i),
    .Branch_i        (Branch_i),
    .MemRead_i       (MemRead_i),
    .MemWrite_i      (MemWrite_i),
    .RegWrite_i      (RegWrite_i),
    .PC_beq_i        (PC_beq_i),
    .alu_result_i    (alu_result_i),
    .ReadData2_i     (ReadData2_i),
    .zero_flag_i     (zero_flag_i),
    .WriteRegister_i (WriteRegister_i),
    .dmem            (dmem),
    .stall           (stall),
    .PCSrc           (PCSrc),
    .PC_branch       (PC_branch),
    .MemtoReg_o      (MemtoReg_o),
    .RegWrite_o      (RegWrite_o),
    .WriteRegister_o (WriteRegister_o),
    .read_data_o     (read_data_o),
    .alu_result_o    (alu_result_o),
    .bus_err_o       (bus_err_o),
    .misalign_o      (misalign_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_nop();
    MemtoReg_i = 2'b00; Branch_i = 1'b0; MemRead_i = 1'b0; MemWrite_i = 1'b0;
    RegWrite_i = 1'b0; PC_beq_i = 32'd0; alu_result_i = 32'd0; ReadData2_i = 32'd0;
    zero_flag_i = 1'b0; WriteRegister_i = 5'd0;
    dmem.dmem_ack = 1'b0; dmem.dmem_rdata = 32'd0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_nop();
    #12;
    vectors++; if (RegWrite_o !== 1'b0) begin miscompares++; $display("FAIL reset_regwrite: got %b expected 0", RegWrite_o); end
    vectors++; if (read_data_o !== 32'd0) begin miscompares++; $display("FAIL reset_read_data: got %h expected 0", read_data_o); end
    vectors++; if (alu_result_o !== 32'd0) begin miscompares++; $display("FAIL reset_alu_result: got %h expected 0", alu_result_o); end
    vectors++; if (dmem.dmem_req !== 1'b0) begin miscompares++; $display("FAIL reset_req: got %b expected 0", dmem.dmem_req); end
    vectors++; if (bus_err_o !== 1'b0) begin miscompares++; $display("FAIL reset_bus_err: got %b expected 0", bus_err_o); end
    @(negedge clk);
    reset = 1'b0;
    step();
  endtask

  task automatic test_alu();
    set_nop();
    alu_result_i = 32'h1234; RegWrite_i = 1'b1; WriteRegister_i = 5'd5;
    #1;
    vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL alu_stall: got %b expected 0", stall); end
    step();
    vectors++; if (alu_result_o !== 32'h1234) begin miscompares++; $display("FAIL alu_result: got %h expected 00001234", alu_result_o); end
    vectors++; if (RegWrite_o !== 1'b1) begin miscompares++; $display("FAIL alu_regwrite: got %b expected 1", RegWrite_o); end
    vectors++; if (WriteRegister_o !== 5'd5) begin miscompares++; $display("FAIL alu_wreg: got %0d expected 5", WriteRegister_o); end
    vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL alu_stall_after: got %b expected 0", stall); end
  endtask

  task automatic test_load();
    int stall_cycles, req_cycles, bursts;
    logic prev_req;
    stall_cycles = 0; req_cycles = 0; bursts = 0; prev_req = 1'b0;
    set_nop();
    MemRead_i = 1'b1; MemtoReg_i = 2'b01; alu_result_i = 32'h100; RegWrite_i = 1'b1; WriteRegister_i = 5'd7;
    for (int k = 0; k < 5; k++) begin
      dmem.dmem_ack   = (k == 4);
      dmem.dmem_rdata = (k == 4) ? 32'hDEADBEEF : 32'd0;
      #1;
      if (stall) stall_cycles++;
      if (dmem.dmem_req) begin
        req_cycles++;
        if (!prev_req) bursts++;
      end
      prev_req = dmem.dmem_req;
      if (k == 4) begin
        vectors++; if (dmem.dmem_addr !== 32'h100) begin miscompares++; $display("FAIL load_addr: got %h expected 00000100", dmem.dmem_addr); end
        vectors++; if (dmem.dmem_we !== 1'b0) begin miscompares++; $display("FAIL load_we: got %b expected 0", dmem.dmem_we); end
      end
      step();
    end
    dmem.dmem_ack = 1'b0;
    vectors++; if (stall_cycles !== 4) begin miscompares++; $display("FAIL load_stall_cycles: got %0d expected 4", stall_cycles); end
    vectors++; if (req_cycles !== 4) begin miscompares++; $display("FAIL load_req_cycles: got %0d expected 4", req_cycles); end
    vectors++; if (bursts !== 1) begin miscompares++; $display("FAIL load_req_bursts: got %0d expected 1", bursts); end
    vectors++; if (read_data_o !== 32'hDEADBEEF) begin miscompares++; $display("FAIL load_read_data: got %h expected deadbeef", read_data_o); end
    vectors++; if (RegWrite_o !== 1'b1) begin miscompares++; $display("FAIL load_regwrite: got %b expected 1", RegWrite_o); end
    vectors++; if (MemtoReg_o !== 2'b01) begin miscompares++; $display("FAIL load_memtoreg: got %b expected 01", MemtoReg_o); end
    vectors++; if (dmem.dmem_req !== 1'b0) begin miscompares++; $display("FAIL load_req_done: got %b expected 0", dmem.dmem_req); end
    set_nop();
    step();
  endtask

  task automatic test_store();
    int stall_cycles;
    stall_cycles = 0;
    set_nop();
    MemWrite_i = 1'b1; alu_result_i = 32'h200; ReadData2_i = 32'hCAFE; RegWrite_i = 1'b0;
    for (int k = 0; k < 2; k++) begin
      dmem.dmem_ack = (k == 1);
      #1;
      if (stall) stall_cycles++;
      if (k == 1) begin
        vectors++; if (dmem.dmem_req !== 1'b1) begin miscompares++; $display("FAIL store_req: got %b expected 1", dmem.dmem_req); end
        vectors++; if (dmem.dmem_we !== 1'b1) begin miscompares++; $display("FAIL store_we: got %b expected 1", dmem.dmem_we); end
        vectors++; if (dmem.dmem_wdata !== 32'hCAFE) begin miscompares++; $display("FAIL store_wdata: got %h expected 0000cafe", dmem.dmem_wdata); end
        vectors++; if (dmem.dmem_addr !== 32'h200) begin miscompares++; $display("FAIL store_addr: got %h expected 00000200", dmem.dmem_addr); end
      end
      step();
    end
    dmem.dmem_ack = 1'b0;
    vectors++; if (stall_cycles !== 1) begin miscompares++; $display("FAIL store_stall_cycles: got %0d expected 1", stall_cycles); end
    vectors++; if (RegWrite_o !== 1'b0) begin miscompares++; $display("FAIL store_regwrite: got %b expected 0", RegWrite_o); end
    vectors++; if (read_data_o !== 32'hDEADBEEF) begin miscompares++; $display("FAIL store_read_data_kept: got %h expected deadbeef", read_data_o); end
    set_nop();
    step();
  endtask

  task automatic test_branch();
    set_nop();
    Branch_i = 1'b1; zero_flag_i = 1'b1; PC_beq_i = 32'h40;
    #1;
    vectors++; if (PCSrc !== 1'b1) begin miscompares++; $display("FAIL branch_taken: got %b expected 1", PCSrc); end
    vectors++; if (PC_branch !== 32'h40) begin miscompares++; $display("FAIL branch_target: got %h expected 00000040", PC_branch); end
    zero_flag_i = 1'b0;
    #1;
    vectors++; if (PCSrc !== 1'b0) begin miscompares++; $display("FAIL branch_not_zero: got %b expected 0", PCSrc); end
    Branch_i = 1'b0; zero_flag_i = 1'b1;
    #1;
    vectors++; if (PCSrc !== 1'b0) begin miscompares++; $display("FAIL branch_not_branch: got %b expected 0", PCSrc); end
    set_nop();
    step();
  endtask

  task automatic test_align();
    set_nop();
    MemRead_i = 1'b1; alu_result_i = 32'h102; RegWrite_i = 1'b1; WriteRegister_i = 5'd3;
    #1;
`ifdef MEM_ALIGN_CHECK_EN
    vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL misalign_stall: got %b expected 0", stall); end
    step();
    vectors++; if (misalign_o !== 1'b1) begin miscompares++; $display("FAIL misalign_pulse: got %b expected 1", misalign_o); end
    vectors++; if (RegWrite_o !== 1'b0) begin miscompares++; $display("FAIL misalign_regwrite: got %b expected 0", RegWrite_o); end
    vectors++; if (dmem.dmem_req !== 1'b0) begin miscompares++; $display("FAIL misalign_req: got %b expected 0", dmem.dmem_req); end
    set_nop();
    step();
    vectors++; if (misalign_o !== 1'b0) begin miscompares++; $display("FAIL misalign_pulse_end: got %b expected 0", misalign_o); end
`else
    vectors++; if (stall !== 1'b1) begin miscompares++; $display("FAIL align_stall: got %b expected 1", stall); end
    step();
    dmem.dmem_ack = 1'b1; dmem.dmem_rdata = 32'h5555AAAA;
    #1;
    vectors++; if (dmem.dmem_addr !== 32'h100) begin miscompares++; $display("FAIL align_addr_forced: got %h expected 00000100", dmem.dmem_addr); end
    step();
    dmem.dmem_ack = 1'b0;
    vectors++; if (misalign_o !== 1'b0) begin miscompares++; $display("FAIL align_misalign_tied: got %b expected 0", misalign_o); end
    vectors++; if (read_data_o !== 32'h5555AAAA) begin miscompares++; $display("FAIL align_read_data: got %h expected 5555aaaa", read_data_o); end
    set_nop();
    step();
`endif
  endtask

  task automatic test_timeout();
    int n;
    n = 0;
    set_nop();
    MemRead_i = 1'b1; alu_result_i = 32'h300; RegWrite_i = 1'b1; WriteRegister_i = 5'd9;
    #1;
    while (stall && n < 400) begin
      n++;
      step();
    end
    vectors++; if (n !== 256) begin miscompares++; $display("FAIL timeout_stall_cycles: got %0d expected 256", n); end
    vectors++; if (dmem.dmem_req !== 1'b1) begin miscompares++; $display("FAIL timeout_req_abort_cycle: got %b expected 1", dmem.dmem_req); end
    step();
    vectors++; if (bus_err_o !== 1'b1) begin miscompares++; $display("FAIL timeout_bus_err: got %b expected 1", bus_err_o); end
    vectors++; if (RegWrite_o !== 1'b0) begin miscompares++; $display("FAIL timeout_regwrite: got %b expected 0", RegWrite_o); end
    vectors++; if (read_data_o !== 32'd0) begin miscompares++; $display("FAIL timeout_read_data: got %h expected 0", read_data_o); end
    vectors++; if (dmem.dmem_req !== 1'b0) begin miscompares++; $display("FAIL timeout_req_released: got %b expected 0", dmem.dmem_req); end
    set_nop();
    step();
    vectors++; if (bus_err_o !== 1'b0) begin miscompares++; $display("FAIL timeout_bus_err_end: got %b expected 0", bus_err_o); end
  endtask

  task automatic test_reset_mid_access();
    set_nop();
    // Leave a non-zero value in MEM/WB so the reset clear is observable.
    alu_result_i = 32'hABCD; RegWrite_i = 1'b1;
    step();
    set_nop();
    MemRead_i = 1'b1; alu_result_i = 32'h400; RegWrite_i = 1'b1;
    step();
    step();
    #1;
    vectors++; if (dmem.dmem_req !== 1'b1) begin miscompares++; $display("FAIL midreset_req_before: got %b expected 1", dmem.dmem_req); end
    #2;
    reset = 1'b1;
    #1;
    vectors++; if (dmem.dmem_req !== 1'b0) begin miscompares++; $display("FAIL midreset_req_drop: got %b expected 0", dmem.dmem_req); end
    vectors++; if (alu_result_o !== 32'd0) begin miscompares++; $display("FAIL midreset_alu_cleared: got %h expected 0", alu_result_o); end
    step();
    set_nop();
    reset = 1'b0;
    dmem.dmem_ack = 1'b1; dmem.dmem_rdata = 32'h12345678;
    #1;
    vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL midreset_stall: got %b expected 0", stall); end
    step();
    dmem.dmem_ack = 1'b0;
    vectors++; if (read_data_o !== 32'd0) begin miscompares++; $display("FAIL midreset_late_ack: got %h expected 0", read_data_o); end
    vectors++; if (RegWrite_o !== 1'b0) begin miscompares++; $display("FAIL midreset_regwrite: got %b expected 0", RegWrite_o); end
    vectors++; if (dmem.dmem_req !== 1'b0) begin miscompares++; $display("FAIL midreset_req_idle: got %b expected 0", dmem.dmem_req); end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_alu();
    test_load();
    test_store();
    test_branch();
    test_align();
    test_timeout();
    test_reset_mid_access();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
